// File: rtl/i2c_eeprom_slave_if.sv
// i2c_eeprom_slave_if: serial clock plus the write-report and busy signals between a bus master and the EEPROM slave.
// SDA stays a plain open-drain inout on the slave so it resolves as a single wired net.
interface i2c_eeprom_slave_if #(
  parameter int ADDR_W = 11
);
  logic              scl;
  logic              busy;
  logic              wrStb;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0]        wrData;

  modport master (output scl, input busy, wrStb, wrAddr, wrData);
  modport slave  (input scl, output busy, wrStb, wrAddr, wrData);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: 2048x8 serial-EEPROM device end of the 2-wire bus (control byte 1010_AAA_RW).
// Define EEPROM_PAGE_WR_EN for 16-byte page writes; by default a write accepts a single data byte.
module i2c_eeprom_slave #(
  parameter logic [3:0] DEV_ID   = 4'b1010,
  parameter int         ADDR_W   = 11,
  parameter logic [7:0] INIT_VAL = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  i2c_eeprom_slave_if.slave bus_if,
  inout  wire               sda_io
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [9:0] IDLE      = 10'h001;
  localparam logic [9:0] CTRL      = 10'h002;
  localparam logic [9:0] CTRL_ACK  = 10'h004;
  localparam logic [9:0] ADDR      = 10'h008;
  localparam logic [9:0] ADDR_ACK  = 10'h010;
  localparam logic [9:0] WDATA     = 10'h020;
  localparam logic [9:0] WDATA_ACK = 10'h040;
  localparam logic [9:0] RDATA     = 10'h080;
  localparam logic [9:0] RDATA_ACK = 10'h100;
  localparam logic [9:0] IGNORE    = 10'h200;

  logic [1:0]        sclSync_q, sdaSync_q;
  logic              sclHist_q, sdaHist_q;
  logic [9:0]        state_q, state_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        shReg_q, shReg_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              ackOn_q, ackOn_d;
  logic              sdaLow_q, sdaLow_d;
  logic              busy_q, busy_d;
  logic              wrStb_q, wrStb_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]        wrData_q, wrData_d;
  logic              memWe;
  logic [7:0]        mem_q [DEPTH];

  logic       sclS, sdaS, sclRise, sclFall, startDet, stopDet;
  logic [7:0] byteIn, rdByte;
  logic [2:0] rdIdx;

  assign sclS     = sclSync_q[1];
  assign sdaS     = sdaSync_q[1];
  assign sclRise  = sclS & ~sclHist_q;
  assign sclFall  = ~sclS & sclHist_q;
  assign startDet = sclS & sclHist_q & sdaHist_q & ~sdaS;
  assign stopDet  = sclS & sclHist_q & ~sdaHist_q & sdaS;
  assign byteIn   = {shReg_q[6:0], sdaS};
  assign rdByte   = mem_q[ptr_q];
  assign rdIdx    = 3'd7 - bitCnt_q[2:0];

  assign sda_io        = sdaLow_q ? 1'b0 : 1'bz;
  assign bus_if.busy   = busy_q;
  assign bus_if.wrStb  = wrStb_q;
  assign bus_if.wrAddr = wrAddr_q;
  assign bus_if.wrData = wrData_q;

  // Synchronizers idle high so leaving reset never fakes a START, STOP or SCL edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclHist_q <= 1'b1;
      sdaHist_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[0], bus_if.scl};
      sdaSync_q <= {sdaSync_q[0], sda_io};
      sclHist_q <= sclSync_q[1];
      sdaHist_q <= sdaSync_q[1];
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shReg_d  = shReg_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ackOn_d  = ackOn_q;
    sdaLow_d = sdaLow_q;
    busy_d   = busy_q;
    wrStb_d  = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    memWe    = 1'b0;
    if (startDet) begin
      state_d  = CTRL;
      bitCnt_d = 4'd0;
      ackOn_d  = 1'b0;
      sdaLow_d = 1'b0;
    end else if (stopDet) begin
      state_d  = IDLE;
      bitCnt_d = 4'd0;
      ackOn_d  = 1'b0;
      sdaLow_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        CTRL, ADDR, WDATA: if (sclRise) begin
          shReg_d  = byteIn;
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q == 4'd7) begin
            bitCnt_d = 4'd0;
            case (state_q)
              CTRL: if (byteIn[7:4] == DEV_ID) begin
                ptr_d[ADDR_W-1:8] = byteIn[ADDR_W-8:1];
                rw_d    = byteIn[0];
                busy_d  = 1'b1;
                state_d = CTRL_ACK;
              end else begin
                state_d = IDLE;
              end
              ADDR: begin
                ptr_d[7:0] = byteIn;
                state_d    = ADDR_ACK;
              end
              default: begin
                memWe    = 1'b1;
                wrStb_d  = 1'b1;
                wrAddr_d = ptr_q;
                wrData_d = byteIn;
                state_d  = WDATA_ACK;
`ifdef EEPROM_PAGE_WR_EN
                ptr_d[3:0] = ptr_q[3:0] + 4'd1;
`else
                ptr_d = ptr_q + ADDR_W'(1);
`endif
              end
            endcase
          end
        end
        // Each ACK slot pulls SDA low for one full SCL low-high-low span, fall to fall.
        CTRL_ACK, ADDR_ACK, WDATA_ACK: if (sclFall) begin
          if (!ackOn_q) begin
            ackOn_d  = 1'b1;
            sdaLow_d = 1'b1;
          end else begin
            ackOn_d  = 1'b0;
            sdaLow_d = 1'b0;
            bitCnt_d = 4'd0;
            case (state_q)
              CTRL_ACK: if (rw_q) begin
                state_d  = RDATA;
                sdaLow_d = ~rdByte[7];
                bitCnt_d = 4'd1;
              end else begin
                state_d = ADDR;
              end
              ADDR_ACK: state_d = WDATA;
`ifdef EEPROM_PAGE_WR_EN
              default:  state_d = WDATA;
`else
              default:  state_d = IGNORE;
`endif
            endcase
          end
        end
        RDATA: if (sclFall) begin
          if (bitCnt_q == 4'd8) begin
            sdaLow_d = 1'b0;
            bitCnt_d = 4'd0;
            state_d  = RDATA_ACK;
          end else begin
            sdaLow_d = ~rdByte[rdIdx];
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
        RDATA_ACK: if (sclRise) begin
          if (!sdaS) begin
            ptr_d    = ptr_q + ADDR_W'(1);
            bitCnt_d = 4'd0;
            state_d  = RDATA;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bitCnt_q <= 4'd0;
      shReg_q  <= 8'h00;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      ackOn_q  <= 1'b0;
      sdaLow_q <= 1'b0;
      busy_q   <= 1'b0;
      wrStb_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shReg_q  <= shReg_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      ackOn_q  <= ackOn_d;
      sdaLow_q <= sdaLow_d;
      busy_q   <= busy_d;
      wrStb_q  <= wrStb_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else if (memWe) begin
      mem_q[ptr_q] <= byteIn;
    end
  end
endmodule
